// File: rtl/toom8_eval_if.sv
// toom8_eval_if: operand / evaluation-result bundle for toom8_eval.
//   X, Y          : 1024-bit unsigned operands (eight 128-bit limbs each)
//   a0..a13, ainf : P_A evaluated at 0, +-1, +-2, +-3, +-4, +-5, +-6, 7, inf
//   b0..b13, binf : P_B evaluated at the same points
//   product       : reference X*Y (zero unless TOOM8_REF_PRODUCT_EN)
// master drives the operands and receives the results; slave is the evaluator.
interface toom8_eval_if;
    logic        [1023:0] X;
    logic        [1023:0] Y;
    logic signed [128:0]  a0, b0, ainf, binf;
    logic signed [131:0]  a1, a2, b1, b2;
    logic signed [138:0]  a3, a4, b3, b4;
    logic signed [143:0]  a5, a6, b5, b6;
    logic signed [147:0]  a7, a8, b7, b8;
    logic signed [148:0]  a9, a10, b9, b10;
    logic signed [149:0]  a11, a12, b11, b12;
    logic signed [154:0]  a13, b13;
    logic        [2047:0] product;

    modport master (
        output X, Y,
        input  a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, ainf,
        input  b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, binf,
        input  product
    );

    modport slave (
        input  X, Y,
        output a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, ainf,
        output b0, b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, binf,
        output product
    );
endinterface

// File: rtl/toom8_eval.sv
// toom8_eval: Toom-8 evaluation stage for a 1024x1024-bit multiplier.
// Each operand is split into eight 128-bit limbs and evaluated as a degree-7
// polynomial at 0, +-1..+-6, 7 and infinity. One register stage, latency 1,
// a new operand pair every cycle, synchronous active-high reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every output
//   bus  : toom8_eval_if.slave (X, Y in; a*, b*, product out)
// Build option: define TOOM8_REF_PRODUCT_EN to register the full X*Y on
// bus.product for verification; otherwise product is tied to zero.

// Evaluates one polynomial and registers all fifteen points.
module toom8_poly (
    input  logic                clk,
    input  logic                rst,
    input  logic        [1023:0] v,
    output logic signed [128:0] p0,
    output logic signed [128:0] pinf,
    output logic signed [131:0] p1, m1,
    output logic signed [138:0] p2, m2,
    output logic signed [143:0] p3, m3,
    output logic signed [147:0] p4, m4,
    output logic signed [148:0] p5, m5,
    output logic signed [149:0] p6, m6,
    output logic signed [154:0] p7
);
    localparam int W = 156;
    typedef logic signed [W-1:0] acc_t;

    acc_t l  [8];
    acc_t ev [1:7];   // even-index partial sum E(k)
    acc_t od [1:7];   // odd-index partial sum O(k)

    for (genvar i = 0; i < 8; i++) begin : g_limb
        assign l[i] = acc_t'({28'd0, v[128*i +: 128]});
    end

    // Constant multiply as a shift-add chain; c is always an elaboration
    // constant here, so only the shifted copies for its set bits remain.
    function automatic acc_t mulc(input acc_t x, input int unsigned c);
        acc_t acc;
        acc = '0;
        for (int j = 0; j < 20; j++)
            if (c[j]) acc = acc + (x << j);
        return acc;
    endfunction

    // E(k) and O(k) are shared by P(+k) = E+O and P(-k) = E-O.
    always_comb begin
        for (int unsigned k = 1; k <= 7; k++) begin
            ev[k] = l[0] + mulc(l[2], k**2) + mulc(l[4], k**4) + mulc(l[6], k**6);
            od[k] = mulc(l[1], k) + mulc(l[3], k**3) + mulc(l[5], k**5)
                  + mulc(l[7], k**7);
        end
    end

    // Results fit their port widths, so the narrowing casts drop only
    // sign copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0 <= '0; pinf <= '0;
            p1 <= '0; m1 <= '0;
            p2 <= '0; m2 <= '0;
            p3 <= '0; m3 <= '0;
            p4 <= '0; m4 <= '0;
            p5 <= '0; m5 <= '0;
            p6 <= '0; m6 <= '0;
            p7 <= '0;
        end else begin
            p0   <= 129'(l[0]);
            pinf <= 129'(l[7]);
            p1   <= 132'(ev[1] + od[1]);  m1 <= 132'(ev[1] - od[1]);
            p2   <= 139'(ev[2] + od[2]);  m2 <= 139'(ev[2] - od[2]);
            p3   <= 144'(ev[3] + od[3]);  m3 <= 144'(ev[3] - od[3]);
            p4   <= 148'(ev[4] + od[4]);  m4 <= 148'(ev[4] - od[4]);
            p5   <= 149'(ev[5] + od[5]);  m5 <= 149'(ev[5] - od[5]);
            p6   <= 150'(ev[6] + od[6]);  m6 <= 150'(ev[6] - od[6]);
            p7   <= 155'(ev[7] + od[7]);
        end
    end
endmodule

module toom8_eval (
    input  logic          clk,
    input  logic          rst,
    toom8_eval_if.slave   bus
);
    toom8_poly u_pa (
        .clk (clk), .rst (rst), .v (bus.X),
        .p0  (bus.a0),  .pinf (bus.ainf),
        .p1  (bus.a1),  .m1   (bus.a2),
        .p2  (bus.a3),  .m2   (bus.a4),
        .p3  (bus.a5),  .m3   (bus.a6),
        .p4  (bus.a7),  .m4   (bus.a8),
        .p5  (bus.a9),  .m5   (bus.a10),
        .p6  (bus.a11), .m6   (bus.a12),
        .p7  (bus.a13)
    );

    toom8_poly u_pb (
        .clk (clk), .rst (rst), .v (bus.Y),
        .p0  (bus.b0),  .pinf (bus.binf),
        .p1  (bus.b1),  .m1   (bus.b2),
        .p2  (bus.b3),  .m2   (bus.b4),
        .p3  (bus.b5),  .m3   (bus.b6),
        .p4  (bus.b7),  .m4   (bus.b8),
        .p5  (bus.b9),  .m5   (bus.b10),
        .p6  (bus.b11), .m6   (bus.b12),
        .p7  (bus.b13)
    );

`ifdef TOOM8_REF_PRODUCT_EN
    // Reference product for checking the downstream stages only.
    always_ff @(posedge clk) begin
        if (rst) bus.product <= '0;
        else     bus.product <= 2048'(bus.X) * 2048'(bus.Y);
    end
`else
    assign bus.product = '0;
`endif
endmodule

// File: tb/tb_toom8_eval.sv
module tb_toom8_eval;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toom8_eval_if bus();
    toom8_eval dut (.clk(clk), .rst(rst), .bus(bus));

    typedef logic signed [155:0] val_t;
    typedef struct {
        logic [1023:0]    x;
        logic [1023:0]    y;
        val_t             sa;  // scale for the A coefficient list
        val_t             sb;
        logic [0:14][31:0] ca; // P_A/sa at 0,1,-1,2,-2,...,6,-6,7,inf
        logic [0:14][31:0] cb;
    } vec_t;

    vec_t tv [5];
    int   errors = 0;
    int   checks = 0;
    val_t ga [15];
    val_t gb [15];
    val_t m;

    always_comb begin
        ga[0]  = bus.a0;  ga[1]  = bus.a1;  ga[2]  = bus.a2;  ga[3]  = bus.a3;
        ga[4]  = bus.a4;  ga[5]  = bus.a5;  ga[6]  = bus.a6;  ga[7]  = bus.a7;
        ga[8]  = bus.a8;  ga[9]  = bus.a9;  ga[10] = bus.a10; ga[11] = bus.a11;
        ga[12] = bus.a12; ga[13] = bus.a13; ga[14] = bus.ainf;
        gb[0]  = bus.b0;  gb[1]  = bus.b1;  gb[2]  = bus.b2;  gb[3]  = bus.b3;
        gb[4]  = bus.b4;  gb[5]  = bus.b5;  gb[6]  = bus.b6;  gb[7]  = bus.b7;
        gb[8]  = bus.b8;  gb[9]  = bus.b9;  gb[10] = bus.b10; gb[11] = bus.b11;
        gb[12] = bus.b12; gb[13] = bus.b13; gb[14] = bus.binf;
    end

    task automatic chk(input string nm, input val_t got, input val_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic chk_vec(input int i, input string nm);
        val_t e;
        for (int j = 0; j < 15; j++) begin
            e = tv[i].sa * $signed(tv[i].ca[j]);
            chk($sformatf("%s v%0d a[%0d]", nm, i, j), ga[j], e);
            e = tv[i].sb * $signed(tv[i].cb[j]);
            chk($sformatf("%s v%0d b[%0d]", nm, i, j), gb[j], e);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("%s a[%0d]", nm, j), ga[j], '0);
            chk($sformatf("%s b[%0d]", nm, j), gb[j], '0);
        end
    endtask

    task automatic chk_prod(input string nm, input logic [2047:0] exp);
        checks++;
        if (bus.product !== exp) begin
            errors++;
            $display("FAIL %s product got_hi=%h got_lo=%h exp_hi=%h exp_lo=%h", nm,
                     bus.product[2047:1920], bus.product[127:0], exp[2047:1920], exp[127:0]);
        end
    endtask

    function automatic logic [2047:0] ref_prod(input logic [1023:0] x, input logic [1023:0] y);
`ifdef TOOM8_REF_PRODUCT_EN
        return 2048'(x) * 2048'(y);
`else
        return '0;
`endif
    endfunction

    task automatic drive(input int i);
        bus.X = tv[i].x;
        bus.Y = tv[i].y;
    endtask

    initial begin
        m = {28'd0, {128{1'b1}}};

        // top limb only: P(+-k) = +-k^7
        tv[0].x  = 1024'(1) << 896;  tv[0].y = 1024'(1) << 896;
        tv[0].sa = 1;                tv[0].sb = 1;
        tv[0].ca = '{0, 1, -1, 128, -128, 2187, -2187, 16384, -16384,
                     78125, -78125, 279936, -279936, 823543, 1};
        tv[0].cb = tv[0].ca;
        // bottom limb only
        tv[1].x  = 1024'(1);         tv[1].y = 1024'(5);
        tv[1].sa = 1;                tv[1].sb = 5;
        tv[1].ca = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        tv[1].cb = tv[1].ca;
        // all ones: (2^128-1) * sum of (+-k)^i
        tv[2].x  = '1;               tv[2].y = '1;
        tv[2].sa = m;                tv[2].sb = m;
        tv[2].ca = '{1, 8, 0, 255, -85, 3280, -1640, 21845, -13107,
                     97656, -65104, 335923, -239945, 960800, 1};
        tv[2].cb = tv[2].ca;
        // x3 = 3 (odd term, sign flips); y2 = 2^128-1 (even term, no flip)
        tv[3].x  = 1024'(3) << 384;
        tv[3].y  = {896'd0, {128{1'b1}}} << 256;
        tv[3].sa = 3;                tv[3].sb = m;
        tv[3].ca = '{0, 1, -1, 8, -8, 27, -27, 64, -64, 125, -125, 216, -216, 343, 0};
        tv[3].cb = '{0, 1, 1, 4, 4, 9, 9, 16, 16, 25, 25, 36, 36, 49, 0};
        // x0 = x1 = 1 -> 1+-k ; y6 = 7 -> 7*k^6
        tv[4].x  = (1024'(1) << 128) | 1024'(1);
        tv[4].y  = 1024'(7) << 768;
        tv[4].sa = 1;                tv[4].sb = 7;
        tv[4].ca = '{1, 2, 0, 3, -1, 4, -2, 5, -3, 6, -4, 7, -5, 8, 0};
        tv[4].cb = '{0, 1, 1, 64, 64, 729, 729, 4096, 4096, 15625, 15625,
                     46656, 46656, 117649, 0};

        // reset held 3 cycles with nonzero operands
        rst = 1'b1;
        drive(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        chk_prod("reset", '0);
        rst = 1'b0;
        @(negedge clk);
        chk_vec(2, "post_reset");
        chk_prod("post_reset", ref_prod(tv[2].x, tv[2].y));

        // table: apply each vector, check one edge later, then again held
        for (int i = 0; i < 5; i++) begin
            drive(i);
            @(negedge clk);
            chk_vec(i, "table");
            chk_prod($sformatf("table v%0d", i), ref_prod(tv[i].x, tv[i].y));
            @(negedge clk);
            chk_vec(i, "hold");
        end

`ifdef TOOM8_REF_PRODUCT_EN
        drive(0);
        @(negedge clk);
        chk_prod("top_limb", 2048'(1) << 1792);
`endif

        // back-to-back: new operands every cycle, results track previous edge
        for (int c = 0; c < 10; c++) begin
            drive(c % 5);
            @(negedge clk);
            chk_vec(c % 5, "stream");
            chk_prod($sformatf("stream c%0d", c), ref_prod(tv[c % 5].x, tv[c % 5].y));
        end

        // reset wins over the same-edge sample
        drive(0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_prio");
        chk_prod("rst_prio", '0);
        rst = 1'b0;
        @(negedge clk);
        chk_vec(0, "rst_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/toom8_eval.md
# toom8_eval

Evaluation stage of a 1024×1024-bit Toom-8 multiplier.
- Splits each operand into eight 128-bit limbs and treats each operand as a degree-7 polynomial in those limbs.
- Evaluates both polynomials at the 15 points 0, ±1, ±2, ±3, ±4, ±5, ±6, 7, ∞ and registers the results.
- Downstream, a pointwise-multiply stage and an interpolation stage consume these values.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  in  1  — rising-edge clock.
- rst  in  1  — synchronous, active-high reset.
- X  in  1024  — operand A, unsigned. Limb x_i = X[128i+127:128i]; x0 is the least significant limb.
- Y  in  1024  — operand B, unsigned. Limbs y_i are taken the same way.
- a0, b0  out  129 signed  — P(0) = x0 (and y0), zero-extended.
- a1, a2, b1, b2  out  132 signed  — P(1) and P(−1).
- a3, a4, b3, b4  out  139 signed  — P(2) and P(−2).
- a5, a6, b5, b6  out  144 signed  — P(3) and P(−3).
- a7, a8, b7, b8  out  148 signed  — P(4) and P(−4).
- a9, a10, b9, b10  out  149 signed  — P(5) and P(−5).
- a11, a12, b11, b12  out  150 signed  — P(6) and P(−6).
- a13, b13  out  155 signed  — P(7).
- ainf, binf  out  129 signed  — P(∞) = x7 (and y7), zero-extended.
- product  out  2048  — reference product; see Configuration.

## Operation
- The polynomials are P_A(t) = Σ_{i=0..7} x_i·t^i and P_B(t) = Σ_{i=0..7} y_i·t^i. Limbs are unsigned.
- The a-outputs evaluate P_A and the b-outputs evaluate P_B, with identical logic for both.
- Exact results are required:
  - No truncation or rounding.
  - Each result is sign-extended to its port width.
  - Magnitude bounds: |P(±k)| ≤ (2^128−1)·Σ k^i, which fits the port widths with margin.
- Negative points use alternating signs: P(−k) = E(k) − O(k), where E(k) = Σ over even i and O(k) = Σ over odd i. P(+k) = E(k) + O(k). Sharing E and O across the ±k pair is required.
- Multiplications by constants are built from shifts and adds; no generic multipliers on the evaluation path.
- P(0) and P(∞) are pure limb selections.
- Internal arithmetic uses at least 156-bit signed intermediates.

## Timing
- The design is a single register stage with a latency of 1 cycle.
  - X and Y are sampled on a rising edge.
  - All 30 evaluation outputs reflect those inputs immediately after that edge.
  - A new operand pair is accepted every cycle; there is no handshake.
- Reset: when rst = 1 at a rising edge, every output, including product, becomes 0 on that edge.
  - Reset has priority over the input sample taken in the same cycle.
  - Outputs stay 0 while rst is held high.
  - The first valid result appears on the first edge after rst falls.
- Inputs that are constant across edges give constant outputs.

## Configuration
- Macro TOOM8_REF_PRODUCT_EN.
- Defined: product is registered to X·Y, the full 2048-bit unsigned product, with the same 1-cycle latency and reset behaviour as the evaluation outputs. It is a verification reference only.
- Undefined: product is tied to 0 and no multiplier is synthesized.
- The evaluation outputs are identical in both builds.

## Test plan
- Reset: hold rst = 1 for 3 cycles with nonzero X and Y → all outputs are 0. Release rst → outputs are valid one edge later.
- Top limb only, X = Y = 2^896 (x7 = 1):
  - a0 = 0, ainf = 1, a1 = 1, a2 = −1
  - a3 = 128, a4 = −128, a5 = 2187, a6 = −2187
  - a7 = 16384, a9 = 78125, a11 = 279936, a13 = 823543
  - The b-outputs are identical.
- Bottom limb only, X = 1 and Y = 5 → every a-output except ainf is 1, and ainf = 0. Every b-output except binf is 5, and binf = 0.
- All ones, X = Y = 2^1024 − 1 (every limb 2^128 − 1):
  - a1 = 8·(2^128−1), a2 = 0
  - a13 = 960800·(2^128−1)
  - a12 = (2^128−1)·(1−6+36−…−6^7) = (2^128−1)·(−239945)
  - No overflow on any port.
- Back-to-back streaming: change X every cycle for 10 cycles → each output set matches the input of the previous edge. With TOOM8_REF_PRODUCT_EN defined, product equals X·Y from the previous edge; for the top-limb case above, product = 2^1792.
